// File: rtl/max_pool_if.sv
// max_pool_if: load-level handshake plus frame buses between the ELU stage
// and the max-pool stage. The master drives load/d, the slave returns
// valid/q.
`ifndef MP_DATA_LEN
`define MP_DATA_LEN 16
`endif

interface max_pool_if #(
    parameter int ROWS     = 32,
    parameter int CH       = 12,
    parameter int DATA_LEN = `MP_DATA_LEN
);
    logic                               load;
    logic [ROWS*CH*DATA_LEN-1:0]        d;
    logic                               valid;
    logic [(ROWS/2)*CH*DATA_LEN-1:0]    q;

    modport master (output load, output d, input valid, input q);
    modport slave  (input load, input d, output valid, output q);
endinterface

// File: rtl/max_pool_layer.sv
// max_pool_layer: 2:1 row-axis pooling of a ROWS x CH frame into a
// ROWS/2 x CH frame, one output row per cycle through a 2-stage pipeline.
// Stage 1 latches a row pair from d. Stage 2 reduces the pair per channel
// and writes one q row.
// Optional macro POOL_AVG_EN: each output word is the floor average of
// the pair instead of the signed max.
`ifndef MP_DATA_LEN
`define MP_DATA_LEN 16
`endif

// Per-channel reducer: signed max (ties keep a) or floor average.
module max_pool_lane #(
    parameter int DATA_LEN = `MP_DATA_LEN
) (
    input  logic [DATA_LEN-1:0] a,
    input  logic [DATA_LEN-1:0] b,
    output logic [DATA_LEN-1:0] y
);
`ifdef POOL_AVG_EN
    logic signed [DATA_LEN:0] sum;
    // Widen by one bit so the sum cannot wrap. Then shift arithmetically,
    // which floors toward -inf.
    assign sum = $signed({a[DATA_LEN-1], a}) + $signed({b[DATA_LEN-1], b});
    assign y   = DATA_LEN'(sum >>> 1);
`else
    assign y = ($signed(b) > $signed(a)) ? b : a;
`endif
endmodule

module max_pool_layer #(
    parameter int ROWS     = 32,
    parameter int CH       = 12,
    parameter int DATA_LEN = `MP_DATA_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    max_pool_if.slave  bus
);
    localparam int OROWS = ROWS / 2;
    localparam int IDX_W = (OROWS > 1) ? $clog2(OROWS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(OROWS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_n;

    logic [ROWS-1:0][CH-1:0][DATA_LEN-1:0]  d_rows;
    logic [OROWS-1:0][CH-1:0][DATA_LEN-1:0] q_mem;
    logic [CH-1:0][DATA_LEN-1:0]            pair_a, pair_b, pool_y;

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic             s1v;
    logic             rd_fin;   // last pair has been issued
    logic             wr_fin;   // last row has been written
    logic             issue, write;
    logic             valid_r;

    // d is read live. The upstream stage holds it stable while load is high.
    assign d_rows    = bus.d;
    assign bus.q     = q_mem;
    assign bus.valid = valid_r;

    assign issue = bus.load && (state == RUN) && !rd_fin;
    assign write = bus.load && (state == RUN) && s1v;

    // One reducer per channel, all fed from the stage-1 pair registers.
    genvar gc;
    generate
        for (gc = 0; gc < CH; gc++) begin : g_lane
            max_pool_lane #(.DATA_LEN(DATA_LEN)) u_lane (
                .a (pair_a[gc]),
                .b (pair_b[gc]),
                .y (pool_y[gc])
            );
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next state. Dropping load aborts from any state.
    always_comb begin
        state_n = state;
        if (!bus.load) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    state_n = RUN;
                RUN:     if (wr_fin) state_n = DONE;
                DONE:    state_n = DONE;
                default: state_n = IDLE;
            endcase
        end
    end

    // valid is a registered copy of "next state is DONE". It rises one edge
    // after the last row is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_r <= 1'b0;
        else        valid_r <= (state_n == DONE);
    end

    // Pipeline control: stage-1 pair issue, and read/write index tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx <= '0;
            wr_idx <= '0;
            rd_fin <= 1'b0;
            wr_fin <= 1'b0;
            s1v    <= 1'b0;
            pair_a <= '0;
            pair_b <= '0;
        end else if (!bus.load || state == IDLE) begin
            rd_idx <= '0;
            wr_idx <= '0;
            rd_fin <= 1'b0;
            wr_fin <= 1'b0;
            s1v    <= 1'b0;
        end else begin
            s1v <= issue;
            if (issue) begin
                pair_a <= d_rows[{rd_idx, 1'b0}];
                pair_b <= d_rows[{rd_idx, 1'b1}];
                if (rd_idx == LAST) rd_fin <= 1'b1;
                else                rd_idx <= rd_idx + 1'b1;
            end
            if (write) begin
                if (wr_idx == LAST) wr_fin <= 1'b1;
                else                wr_idx <= wr_idx + 1'b1;
            end
        end
    end

    // Output storage. A stage-2 result is written into row wr_idx. Contents
    // are kept across aborts and are cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     q_mem         <= '0;
        else if (write) q_mem[wr_idx] <= pool_y;
    end
endmodule

// File: doc/max_pool_layer.md
Name: max_pool_layer

Overview:
- Stage directly downstream of the ELU layer. Its load input connects to the ELU layer's valid, and its d input connects to the ELU layer's q.
- Performs 2:1 max pooling along the row axis of a 32-row × 12-channel activation frame and produces a 16-row × 12-channel frame.
- Processes one output row per cycle with a 2-stage pipeline, then raises valid and holds it, using the same load-level protocol as the ELU stage.

Parameters:
- ROWS, 32, input rows per frame; must be even.
- CH, 12, channels per row; one comparator per channel.
- DATA_LEN, `data_len, bits per word; words are two's-complement signed.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  level request; held high for the whole operation, low to clear/restart.
- d  in  ROWS*CH*DATA_LEN  input frame.
  - Row j is at d[j*CH*DATA_LEN +: CH*DATA_LEN].
  - Channel i within a row is at offset i*DATA_LEN.
- valid  out  1  registered; high when q holds the complete pooled frame.
- q  out  (ROWS/2)*CH*DATA_LEN  pooled frame, same packing as d; driven from registered storage.

Behaviour:
- Reset (rst_n low, asynchronous):
  - valid=0; state=IDLE; rd_idx=0; wr_idx=0; stage-1 valid bit s1v=0.
  - All q storage cleared to 0.
- d must be stable while load is high. The block reads d directly and does not snapshot it.
- States: IDLE, RUN, DONE.
  - IDLE: if load=1 at a rising edge, go to RUN with rd_idx=0. Otherwise stay in IDLE.
  - RUN, stage 1, on each edge:
    - pair_a <= row 2*rd_idx; pair_b <= row 2*rd_idx+1; s1v <= 1.
    - rd_idx increments, saturating at ROWS/2-1.
    - After the pair with rd_idx = ROWS/2-1 is issued, no further pairs issue and s1v <= 0.
  - RUN, stage 2, on each edge with s1v=1:
    - For each channel c: q_row[wr_idx][c] <= signed max(pair_a[c], pair_b[c]). When the two are equal, pair_a is used.
    - wr_idx then increments.
  - When the write to wr_idx = ROWS/2-1 completes, go to DONE on the next edge and set valid=1.
  - DONE: valid stays 1 and q stays static while load=1.
- Latency, counting edge 1 as the first rising edge with load=1 in IDLE:
  - Pair reads occur at edges 2..17 and writes at edges 3..18.
  - valid is high after edge 19, i.e. ROWS/2+3 edges for the default parameters.
- load=0 at any edge, in any state including mid-RUN:
  - Next state IDLE; valid=0; rd_idx=0; wr_idx=0; s1v=0.
  - q contents are retained but carry no meaning until valid is asserted again.
- load=0→1 again: the operation restarts from row 0. Rows are overwritten in order.
- Comparison is a full signed compare: 0x8000 < 0x7FFF for DATA_LEN=16. There is no saturation, because max cannot overflow.
- Asserting rst_n low mid-operation forces the reset values immediately. Operation resumes only after rst_n goes high and load is sampled high in IDLE.

Optional Feature:
- Macro: POOL_AVG_EN.
- Defined: each output word is the average of the pair.
  - Compute (a+b) in DATA_LEN+1 bits, sign-extended, then arithmetic shift right by 1 (floor toward −inf).
  - Truncate to DATA_LEN bits.
  - Latency and handshake are unchanged.
- Undefined: signed max, as specified in Behaviour.

Test Plan:
- Reset/idle: rst_n=0 then 1, load=0 for 5 cycles → valid=0 and q=all zeros throughout.
- Basic max: row r channel c = r*16+c (r=0..31, c=0..11), load held high →
  - valid rises after edge 19;
  - q row k channel c = (2k+1)*16+c.
  - Without POOL_AVG_EN, q row 0 ch 0 = 16 and row 15 ch 11 = 507.
- Signed/equal values:
  - Row0 ch0=0xFFF0 (−16), row1 ch0=0x0003 → out 0x0003.
  - Row0 ch1=0x8000, row1 ch1=0xFFFF → out 0xFFFF.
  - Equal pair 0x1234/0x1234 → 0x1234.
- Abort mid-run: drop load at edge 10, hold low 2 cycles, raise again →
  - valid=0 during the gap;
  - a full restart gives valid after edge 19 of the new run and correct q.
- Async reset mid-run: pulse rst_n low between edges 8 and 9 → valid=0 and q=0 immediately, with no clock edge required.
- POOL_AVG_EN build:
  - Pair 0x0003/0x0004 → 0x0003.
  - Pair 0xFFFF/0x0000 → 0xFFFF (−1).
  - Pair 0x7FFF/0x7FFF → 0x7FFF.
  - valid timing is unchanged.
